// File: rtl/bist_sequencer.sv
// Logic-BIST control FSM: clears the LFSR/MISR datapath, enables it for PATTERN_COUNT cycles,
// settles one cycle and compares the MISR signature. Optional BIST_SIG_CAPTURE_EN adds sig_cap.
module bist_sequencer #(
  parameter int unsigned      PATTERN_COUNT = 10,
  parameter int unsigned      CNT_W         = 8,
  parameter int unsigned      SIG_W         = 4,
  parameter logic [SIG_W-1:0] GOLDEN_SIG    = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] misr_sig,
  output logic             dp_clr,
  output logic             dp_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pat_cnt
`ifdef BIST_SIG_CAPTURE_EN
  ,
  output logic [SIG_W-1:0] sig_cap
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] pat_cnt_nxt;
  logic             pass_nxt;

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_nxt = S_SEED;
      S_SEED:   state_nxt = S_RUN;
      S_RUN:    if (pat_cnt == CNT_LAST) state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_DONE;
      S_DONE:   if (start) state_nxt = S_SEED;
      default:  state_nxt = S_IDLE;
    endcase
    // abort overrides everything, including a simultaneous start
    if (abort) state_nxt = S_IDLE;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    pat_cnt_nxt = pat_cnt;
    if (state_nxt == S_SEED)
      pat_cnt_nxt = '0;
    else if (state_q == S_RUN && state_nxt != S_IDLE)
      pat_cnt_nxt = pat_cnt + CNT_ONE;

    pass_nxt = 1'b0;
    if (state_nxt == S_DONE)
      pass_nxt = (state_q == S_CHECK) ? (misr_sig == GOLDEN_SIG) : pass;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dp_clr  <= 1'b0;
      dp_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      pat_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      dp_clr  <= (state_nxt == S_SEED);
      dp_en   <= (state_nxt == S_RUN);
      busy    <= (state_nxt == S_SEED) || (state_nxt == S_RUN) ||
                 (state_nxt == S_SETTLE) || (state_nxt == S_CHECK);
      done    <= (state_nxt == S_DONE);
      pass    <= pass_nxt;
      pat_cnt <= pat_cnt_nxt;
    end
  end

`ifdef BIST_SIG_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sig_cap <= '0;
    else if (state_nxt == S_SEED)
      sig_cap <= '0;
    else if (state_q == S_CHECK && state_nxt == S_DONE)
      sig_cap <= misr_sig;
  end
`endif

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer with a small MISR model standing in for the datapath.
// Also exercises the BIST_SIG_CAPTURE_EN port when that macro is defined.
module tb_bist_sequencer;

  logic clk = 1'b0;
  logic rst, start, abort, start1, abort1, stuck;
  logic dp_clr, dp_en, busy, done, pass;
  logic [7:0] pat_cnt;
  logic dp_clr1, dp_en1, busy1, done1, pass1;
  logic [7:0] pat_cnt1;
  logic [3:0] misr0 = '0;
  logic [3:0] misr1 = '0;
  logic [3:0] data_check;
`ifdef BIST_SIG_CAPTURE_EN
  logic [3:0] sig_cap, sig_cap1;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  int edges, en_cnt, clr_cnt;
  logic f_clr, f_done, f_pass;

  always #5 clk = ~clk;

  // Fault-free response 4'b0111 gives signature 4'b1111 after 10 updates, 4'b0111 after 1.
  assign data_check = stuck ? 4'b0000 : 4'b0111;

  always @(posedge clk) begin
    if (dp_clr) misr0 <= '0;
    else if (dp_en) misr0 <= {misr0[2:0], misr0[3] ^ misr0[2]} ^ data_check;
    if (dp_clr1) misr1 <= '0;
    else if (dp_en1) misr1 <= {misr1[2:0], misr1[3] ^ misr1[2]} ^ data_check;
  end

  bist_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .misr_sig(misr0),
    .dp_clr(dp_clr), .dp_en(dp_en), .busy(busy), .done(done), .pass(pass),
    .pat_cnt(pat_cnt)
`ifdef BIST_SIG_CAPTURE_EN
    , .sig_cap(sig_cap)
`endif
  );

  bist_sequencer #(.PATTERN_COUNT(1), .GOLDEN_SIG(4'b0111)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .misr_sig(misr1),
    .dp_clr(dp_clr1), .dp_en(dp_en1), .busy(busy1), .done(done1), .pass(pass1),
    .pat_cnt(pat_cnt1)
`ifdef BIST_SIG_CAPTURE_EN
    , .sig_cap(sig_cap1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then steps until done rises (bounded); edge 1 is the edge sampling start.
  task automatic run(input logic mid_start, output int n_edges, output int n_en,
                     output int n_clr, output logic e1_clr, output logic e1_done,
                     output logic e1_pass);
    n_edges = 0; n_en = 0; n_clr = 0;
    e1_clr = 1'b0; e1_done = 1'b0; e1_pass = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) begin
        start = 1'b0;
        e1_clr = dp_clr; e1_done = done; e1_pass = pass;
      end
      if (mid_start && i == 5) start = 1'b1;
      if (mid_start && i == 6) start = 1'b0;
      if (dp_en) n_en++;
      if (dp_clr) n_clr++;
      if (done) begin
        n_edges = i;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0; stuck = 1'b0;
    #2;
    check("reset_flags", {27'd0, dp_clr, dp_en, busy, done, pass}, 32'd0);
    check("reset_cnt", {24'd0, pat_cnt}, 32'd0);
    step(); step();
    rst = 1'b1;
    step(); step();
    check("idle_after_reset", {28'd0, dp_clr, dp_en, busy, done}, 32'd0);

    // PATTERN_COUNT=1 instance: SEED, one RUN cycle, SETTLE, CHECK, DONE
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("p1_seed_clr", {31'd0, dp_clr1}, 32'd1);
    step();
    check("p1_run_en", {31'd0, dp_en1}, 32'd1);
    check("p1_run_cnt", {24'd0, pat_cnt1}, 32'd0);
    step();
    check("p1_settle_en", {31'd0, dp_en1}, 32'd0);
    check("p1_settle_cnt", {24'd0, pat_cnt1}, 32'd1);
    step();
    check("p1_check_done", {31'd0, done1}, 32'd0);
    step();
    check("p1_done", {30'd0, done1, pass1}, 32'd3);

    // Normal fault-free run
    run(1'b0, edges, en_cnt, clr_cnt, f_clr, f_done, f_pass);
    check("run1_seed_clr", {31'd0, f_clr}, 32'd1);
    check("run1_latency", edges, 32'd14);
    check("run1_en_cycles", en_cnt, 32'd10);
    check("run1_clr_cycles", clr_cnt, 32'd1);
    check("run1_pass", {31'd0, pass}, 32'd1);
    check("run1_cnt", {24'd0, pat_cnt}, 32'd10);
    check("run1_busy", {31'd0, busy}, 32'd0);
`ifdef BIST_SIG_CAPTURE_EN
    check("run1_sig_cap", {28'd0, sig_cap}, 32'hF);
`endif
    step(); step(); step();
    check("done_hold", {30'd0, done, pass}, 32'd3);
    check("done_hold_cnt", {24'd0, pat_cnt}, 32'd10);

    // Restart from DONE: done/pass drop on the first edge, no IDLE stop
    run(1'b0, edges, en_cnt, clr_cnt, f_clr, f_done, f_pass);
    check("restart_e1", {29'd0, f_clr, f_done, f_pass}, 32'd4);
    check("restart_latency", edges, 32'd14);
    check("restart_en_cycles", en_cnt, 32'd10);
    check("restart_pass", {31'd0, pass}, 32'd1);

    // Stuck-at-0 on the XOR input: signature stays 0000
    stuck = 1'b1;
    run(1'b0, edges, en_cnt, clr_cnt, f_clr, f_done, f_pass);
    check("stuck_latency", edges, 32'd14);
    check("stuck_pass", {31'd0, pass}, 32'd0);
`ifdef BIST_SIG_CAPTURE_EN
    check("stuck_sig_cap", {28'd0, sig_cap}, 32'h0);
`endif
    stuck = 1'b0;

    // abort + start together in DONE: abort wins
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_done_flags", {27'd0, dp_clr, dp_en, busy, done, pass}, 32'd0);
    check("abort_done_cnt", {24'd0, pat_cnt}, 32'd10);
`ifdef BIST_SIG_CAPTURE_EN
    check("abort_sig_cap_held", {28'd0, sig_cap}, 32'h0);
`endif

    // abort on the 5th RUN cycle
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("pre_abort_run", {23'd0, dp_en, pat_cnt}, {23'd0, 1'b1, 8'd4});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_run_flags", {27'd0, dp_clr, dp_en, busy, done, pass}, 32'd0);
    check("abort_run_cnt", {24'd0, pat_cnt}, 32'd4);
    step(); step();
    check("abort_stays_idle", {29'd0, dp_clr, dp_en, busy}, 32'd0);
    run(1'b0, edges, en_cnt, clr_cnt, f_clr, f_done, f_pass);
    check("post_abort_latency", edges, 32'd14);
    check("post_abort_pass", {31'd0, pass}, 32'd1);
    check("post_abort_cnt", {24'd0, pat_cnt}, 32'd10);

    // abort + start together during RUN, then in IDLE
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; abort = 1'b1;
    step();
    check("abort_start_run", {29'd0, dp_clr, dp_en, busy}, 32'd0);
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", {29'd0, dp_clr, dp_en, busy}, 32'd0);

    // start during RUN is ignored
    run(1'b1, edges, en_cnt, clr_cnt, f_clr, f_done, f_pass);
    check("midstart_latency", edges, 32'd14);
    check("midstart_en_cycles", en_cnt, 32'd10);
    check("midstart_clr_cycles", clr_cnt, 32'd1);
    check("midstart_pass", {31'd0, pass}, 32'd1);

    // Asynchronous reset between edges mid-RUN
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("pre_rst_run", {23'd0, busy, pat_cnt}, {23'd0, 1'b1, 8'd2});
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_flags", {27'd0, dp_clr, dp_en, busy, done, pass}, 32'd0);
    check("async_rst_cnt", {24'd0, pat_cnt}, 32'd0);
    step(); step();
    rst = 1'b1;
    step(); step(); step();
    check("post_rst_idle", {28'd0, dp_clr, dp_en, busy, done}, 32'd0);
    run(1'b0, edges, en_cnt, clr_cnt, f_clr, f_done, f_pass);
    check("post_rst_latency", edges, 32'd14);
    check("post_rst_pass", {31'd0, pass}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
